// File: rtl/pc_unit.sv
// Program counter / fetch controller: sequences instruction fetches, applies
// redirects from the branch unit, and traps misaligned redirect targets.
module pc_unit #(
   parameter int unsigned  N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] pc_new,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   input  logic         stall,
   input  logic         halt,
   input  logic         imem_ready,
   output logic [N-1:0] address,
   output logic         imem_req,
   output logic         instr_valid,
   output logic         misalign,
   output logic [N-1:0] trap_addr,
   output logic [31:0]  fetch_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FETCH  = 2'b01,
      HALTED = 2'b10,
      TRAP   = 2'b11
   } state_t;

   state_t state;
   logic   retire;

   // Request and retire are combinational so memory handshakes complete in-cycle.
   always_comb begin
      imem_req    = (state == FETCH);
      retire      = imem_req & imem_ready & ~stall;
      instr_valid = retire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         address     <= RESET_VECTOR;
         misalign    <= 1'b0;
         trap_addr   <= '0;
         fetch_count <= '0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (retire) begin
                  fetch_count <= fetch_count + 32'd1;
                  // Halt outranks any redirect presented alongside it.
                  if (halt) begin
                     state <= HALTED;
                  end else if (branch_taken) begin
                     if (branch_target[1:0] == 2'b00) begin
                        address <= branch_target;
                     end else begin
                        trap_addr <= branch_target;
                        misalign  <= 1'b1;
                        state     <= TRAP;
                     end
                  end else begin
                     address <= pc_new;
                  end
               end
            end
            HALTED: state <= HALTED;
            TRAP:   state <= TRAP;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a PC+4 adder closes the loop and retired
// fetch addresses are checked against a queue of expected addresses.
module tb_pc_unit;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_new;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        stall;
   logic        halt;
   logic        imem_ready;
   logic [31:0] address;
   logic        imem_req;
   logic        instr_valid;
   logic        misalign;
   logic [31:0] trap_addr;
   logic [31:0] fetch_count;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   pc_unit #(.N(32), .RESET_VECTOR(RV)) dut (
      .clk(clk), .rst_n(rst_n), .pc_new(pc_new), .branch_taken(branch_taken),
      .branch_target(branch_target), .stall(stall), .halt(halt),
      .imem_ready(imem_ready), .address(address), .imem_req(imem_req),
      .instr_valid(instr_valid), .misalign(misalign), .trap_addr(trap_addr),
      .fetch_count(fetch_count)
   );

   // External PC+4 adder
   assign pc_new = address + 32'd4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Leaves time at posedge+1 of the IDLE cycle, reset released.
   task automatic do_reset;
      rst_n = 1'b0; branch_taken = 1'b0; branch_target = '0;
      stall = 1'b0; halt = 1'b0; imem_ready = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // From the IDLE cycle, run sequentially with ready=1 until address==tgt.
   task automatic goto_addr(input logic [31:0] tgt);
      bit reached = 0;
      for (logic [31:0] a = RV; a <= tgt; a += 32'd4) exp_q.push_back(a);
      imem_ready = 1'b1;
      for (int i = 0; i < 64 && !reached; i++) begin
         @(posedge clk); #1;
         if (address === tgt) reached = 1;
         else begin
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b1) begin
               bad++; $display("FAIL seq_valid: got %b exp 1 at %h", instr_valid, address);
            end
            if (exp_q.size() == 0) begin
               total++; bad++; $display("FAIL seq_queue: empty at addr %h", address);
            end else begin
               e = exp_q.pop_front(); total++;
               if (address !== e) begin
                  bad++; $display("FAIL seq_addr: got %h exp %h", address, e);
               end
            end
         end
      end
      total++;
      if (!reached) begin
         bad++; $display("FAIL goto_timeout: got %h exp %h", address, tgt);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; halt = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      #2;
      total++;
      if (address !== RV || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          misalign !== 1'b0 || trap_addr !== 32'h0 || fetch_count !== 32'h0) begin
         bad++;
         $display("FAIL reset_async: addr=%h req=%b iv=%b mis=%b ta=%h cnt=%0d exp %h/0/0/0/0/0",
                  address, imem_req, instr_valid, misalign, trap_addr, fetch_count, RV);
      end
      do_reset();
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || address !== RV || fetch_count !== 32'h0) begin
         bad++; $display("FAIL reset_idle: req=%b addr=%h cnt=%0d exp 0/%h/0",
                         imem_req, address, fetch_count, RV);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL reset_first_req: req=%b iv=%b exp 1/0", imem_req, instr_valid);
      end
   endtask

   task automatic test_sequential;
      do_reset();
      goto_addr(32'h10);
      imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (fetch_count !== 32'd4 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
         bad++; $display("FAIL seq_count: cnt=%0d iv=%b req=%b exp 4/0/1",
                         fetch_count, instr_valid, imem_req);
      end
   endtask

   task automatic test_wait_stall;
      // ready, stall, halt, branch_taken per cycle at address 0x8
      logic [3:0] pat [6] = '{4'b0000, 4'b0011, 4'b0000, 4'b1111, 4'b1101, 4'b1000};
      do_reset();
      goto_addr(32'h8);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         imem_ready    = pat[i][3];
         stall         = pat[i][2];
         halt          = pat[i][1];
         branch_taken  = pat[i][0];
         branch_target = 32'h100;
         @(negedge clk);
         total++;
         if (address !== 32'h8 || imem_req !== 1'b1 || fetch_count !== 32'd2 ||
             instr_valid !== (i == 5)) begin
            bad++; $display("FAIL wait_stall[%0d]: addr=%h req=%b cnt=%0d iv=%b exp 8/1/2/%b",
                            i, address, imem_req, fetch_count, instr_valid, (i == 5));
         end
      end
      @(posedge clk); #1;
      stall = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (address !== 32'hC || fetch_count !== 32'd3) begin
         bad++; $display("FAIL wait_release: addr=%h cnt=%0d exp c/3", address, fetch_count);
      end
   endtask

   task automatic test_redirect;
      logic [31:0] tgts [4] = '{32'h100, 32'h0, 32'h40, 32'h0};
      logic        brs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      goto_addr(32'h10);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h40);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         branch_taken = brs[i]; branch_target = tgts[i];
         @(negedge clk);
         e = exp_q.pop_front(); total++;
         if (address !== e || instr_valid !== 1'b1) begin
            bad++; $display("FAIL redirect[%0d]: addr=%h iv=%b exp %h/1", i, address, instr_valid, e);
         end
      end
      @(posedge clk); #1;
      imem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (address !== 32'h44 || fetch_count !== 32'd8) begin
         bad++; $display("FAIL redirect_end: addr=%h cnt=%0d exp 44/8", address, fetch_count);
      end
   endtask

   task automatic test_misalign;
      do_reset();
      goto_addr(32'h20);
      branch_taken = 1'b1; branch_target = 32'h102;
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1) begin
         bad++; $display("FAIL trap_retire: iv=%b exp 1", instr_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         branch_taken = 1'b1; branch_target = 32'h300;
         @(negedge clk);
         total++;
         if (imem_req !== 1'b0 || misalign !== 1'b1 || trap_addr !== 32'h102 ||
             address !== 32'h20 || instr_valid !== 1'b0 || fetch_count !== 32'd9) begin
            bad++;
            $display("FAIL trap_hold[%0d]: req=%b mis=%b ta=%h addr=%h iv=%b cnt=%0d exp 0/1/102/20/0/9",
                     i, imem_req, misalign, trap_addr, address, instr_valid, fetch_count);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (misalign !== 1'b0 || trap_addr !== 32'h0 || address !== RV) begin
         bad++; $display("FAIL trap_reset: mis=%b ta=%h addr=%h exp 0/0/%h",
                         misalign, trap_addr, address, RV);
      end
   endtask

   task automatic test_halt;
      do_reset();
      goto_addr(32'h30);
      halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1) begin
         bad++; $display("FAIL halt_retire: iv=%b exp 1", instr_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
         @(negedge clk);
         total++;
         if (address !== 32'h30 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
             misalign !== 1'b0 || fetch_count !== 32'd13) begin
            bad++; $display("FAIL halt_hold[%0d]: addr=%h req=%b iv=%b mis=%b cnt=%0d exp 30/0/0/0/13",
                            i, address, imem_req, instr_valid, misalign, fetch_count);
         end
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      goto_addr(32'h40);
      imem_ready = 1'b0;
      #2;
      total++;
      if (fetch_count !== 32'd16 || imem_req !== 1'b1) begin
         bad++; $display("FAIL async_pre: cnt=%0d req=%b exp 16/1", fetch_count, imem_req);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (address !== RV || fetch_count !== 32'h0 || misalign !== 1'b0 ||
          imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL async_reset: addr=%h cnt=%0d mis=%b req=%b iv=%b exp %h/0/0/0/0",
                         address, fetch_count, misalign, imem_req, instr_valid, RV);
      end
      imem_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (fetch_count !== 32'h0 || address !== RV) begin
         bad++; $display("FAIL async_abandon: cnt=%0d addr=%h exp 0/%h", fetch_count, address, RV);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_stall();
      test_redirect();
      test_misalign();
      test_halt();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1);
   end

endmodule
